lcd_fifo_sequencer: RTL and testbench

- Drains the 8-bit LCD byte FIFO and drives an HD44780-compatible LCD over its 8-bit parallel bus.
- Runs the power-on init sequence, then pops FIFO bytes one at a time and writes each as a character (RS=1), or as a command (RS=0) when preceded by the escape byte 0xFE.
- Generates E strobe timing and post-write settle delays, so upstream logic only pushes bytes into the FIFO.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_fifo_sequencer_if.sv | 30 +++
 rtl/lcd_write_strobe.sv | 90 +++++++++
 rtl/lcd_fifo_sequencer.sv | 113 +++++++++++
 tb/tb_lcd_fifo_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD FIFO sequencer: state encoding,
// special byte values and the HD44780 power-on init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPowerup,
        StInitLoad,
        StIdle,
        StSetup,
        StPulse,
        StWait
    } lcd_state_e;

    localparam logic [7:0] ESC_BYTE  = 8'hFE;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int unsigned INIT_LEN   = 5;
    localparam int unsigned INIT_IDX_W = 3;

    // 8-bit bus/2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'h38;
            3'd1:    val = 8'h38;
            3'd2:    val = 8'h0C;
            3'd3:    val = 8'h01;
            3'd4:    val = 8'h06;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_fifo_sequencer_if.sv
// FIFO read handshake plus the HD44780 parallel bus, grouped for the sequencer.
interface lcd_fifo_sequencer_if;
    logic [7:0] fifo_out;
    logic       fifo_empty;
    logic       fifo_out_read;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    modport master (
        input  fifo_out,
        input  fifo_empty,
        output fifo_out_read,
        output lcd_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_e
    );

    modport slave (
        output fifo_out,
        output fifo_empty,
        input  fifo_out_read,
        input  lcd_data,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_e
    );
endinterface

// File: rtl/lcd_write_strobe.sv
// Owns the single timing down-counter: the power-up delay, then per write
// SETUP / PULSE (lcd_e high) / WAIT (settle) with a done pulse on the last WAIT cycle.
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 2000000,
    parameter int unsigned EN_PULSE_CYCLES   = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wr_data,
    input  logic       wr_rs,
    output logic       powerup_done,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e
);

    localparam int unsigned MAX_CYCLES =
        max2(max2(POWERUP_CYCLES, EN_PULSE_CYCLES), max2(CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES));
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       lcd_data_q;
    logic             lcd_rs_q;
    logic             lcd_e_q;
    logic             cnt_zero;
    logic [CNT_W-1:0] wait_load;

    assign cnt_zero = (cnt_q == '0);

    // Clear and home need the long settle; judged on the byte already latched
    assign wait_load = (!lcd_rs_q && (lcd_data_q == CMD_CLEAR || lcd_data_q == CMD_HOME))
                     ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StPowerup;
            cnt_q      <= CNT_W'(POWERUP_CYCLES - 1);
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StPowerup: begin
                    if (cnt_zero) state_q <= StIdle;
                    else          cnt_q   <= cnt_q - CNT_W'(1);
                end
                StIdle: begin
                    if (start) begin
                        lcd_data_q <= wr_data;
                        lcd_rs_q   <= wr_rs;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StPulse;
                    cnt_q   <= CNT_W'(EN_PULSE_CYCLES - 1);
                    lcd_e_q <= 1'b1;
                end
                StPulse: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b0;
                        state_q <= StWait;
                        cnt_q   <= wait_load;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StWait: begin
                    if (cnt_zero) state_q <= StIdle;
                    else          cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= StPowerup;
            endcase
        end
    end

    assign powerup_done = (state_q == StPowerup) && cnt_zero;
    assign done         = (state_q == StWait) && cnt_zero;
    assign lcd_data     = lcd_data_q;
    assign lcd_rs       = lcd_rs_q;
    assign lcd_e        = lcd_e_q;

endmodule

// File: rtl/lcd_fifo_sequencer.sv
// Runs the HD44780 init ROM, then drains the byte FIFO into LCD writes;
// a 0xFE prefix turns the following byte into a command (RS=0).
module lcd_fifo_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 2000000,
    parameter int unsigned EN_PULSE_CYCLES   = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic                        clock,
    input  logic                        reset,
    lcd_fifo_sequencer_if.master        bus,
    output logic                        init_done,
    output logic                        busy
);

    // StSetup here covers the whole write; its sub-phases live in lcd_write_strobe
    lcd_state_e            state_q;
    logic [INIT_IDX_W-1:0] idx_q;
    logic                  esc_pending_q;
    logic                  init_done_q;
    logic                  read_q;

    logic       fifo_read;
    logic       esc_hit;
    logic       init_start;
    logic       start;
    logic [7:0] wr_data;
    logic       wr_rs;
    logic       powerup_done;
    logic       strobe_done;
    logic [7:0] strobe_data;
    logic       strobe_rs;
    logic       strobe_e;

    always_comb begin
        // read_q keeps reads apart so the FIFO head can advance between them
        fifo_read  = (state_q == StIdle) && init_done_q && !bus.fifo_empty && !read_q;
        esc_hit    = fifo_read && (bus.fifo_out == ESC_BYTE) && !esc_pending_q;
        init_start = (state_q == StInitLoad);
        start      = init_start || (fifo_read && !esc_hit);
        wr_data    = init_start ? init_rom(idx_q) : bus.fifo_out;
        wr_rs      = init_start ? 1'b0 : !esc_pending_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StPowerup;
            idx_q         <= '0;
            esc_pending_q <= 1'b0;
            init_done_q   <= 1'b0;
            read_q        <= 1'b0;
        end else begin
            read_q <= fifo_read;
            unique case (state_q)
                StPowerup: begin
                    if (powerup_done) state_q <= StInitLoad;
                end
                StInitLoad: state_q <= StSetup;
                StIdle: begin
                    if (esc_hit) begin
                        esc_pending_q <= 1'b1;
                    end else if (fifo_read) begin
                        esc_pending_q <= 1'b0;
                        state_q       <= StSetup;
                    end
                end
                StSetup: begin
                    if (strobe_done) begin
                        if (init_done_q) begin
                            state_q <= StIdle;
                        end else if (idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
                            init_done_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            idx_q   <= idx_q + INIT_IDX_W'(1);
                            state_q <= StInitLoad;
                        end
                    end
                end
                default: state_q <= StPowerup;
            endcase
        end
    end

    lcd_write_strobe #(
        .POWERUP_CYCLES    (POWERUP_CYCLES),
        .EN_PULSE_CYCLES   (EN_PULSE_CYCLES),
        .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_strobe (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .wr_data      (wr_data),
        .wr_rs        (wr_rs),
        .powerup_done (powerup_done),
        .done         (strobe_done),
        .lcd_data     (strobe_data),
        .lcd_rs       (strobe_rs),
        .lcd_e        (strobe_e)
    );

    assign bus.fifo_out_read = fifo_read;
    assign bus.lcd_data      = strobe_data;
    assign bus.lcd_rs        = strobe_rs;
    assign bus.lcd_rw        = 1'b0;
    assign bus.lcd_e         = strobe_e;
    assign init_done         = init_done_q;
    assign busy              = (state_q != StIdle) || !init_done_q;

endmodule

// File: tb/tb_lcd_fifo_sequencer.sv
// Bench for lcd_fifo_sequencer: FIFO model, LCD bus monitor with timing checks,
// a write-stream reference model, vector table, random traffic and mid-write reset.
module tb_lcd_fifo_sequencer;

    localparam int unsigned POWERUP = 20;
    localparam int unsigned EN      = 4;
    localparam int unsigned CMD     = 10;
    localparam int unsigned CLEAR   = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    logic busy;

    lcd_fifo_sequencer_if bus();

    lcd_fifo_sequencer #(
        .POWERUP_CYCLES    (POWERUP),
        .EN_PULSE_CYCLES   (EN),
        .CMD_WAIT_CYCLES   (CMD),
        .CLEAR_WAIT_CYCLES (CLEAR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clock) cyc++;

    // Reference model: expected LCD writes derived from the byte stream
    typedef struct {
        logic [7:0] data;
        logic       rs;
        bit         init;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fifo_q[$];
    bit         model_esc = 1'b0;
    logic [7:0] init_bytes[5];

    function automatic int unsigned wait_of(input logic [7:0] d, input logic rs);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? CLEAR : CMD;
    endfunction

    task automatic model_init();
        wr_t w;
        for (int i = 0; i < 5; i++) begin
            w.data = init_bytes[i];
            w.rs   = 1'b0;
            w.init = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_t w;
        fifo_q.push_back(b);
        if (b == 8'hFE && !model_esc) begin
            model_esc = 1'b1;
        end else begin
            w.data = b;
            w.rs   = !model_esc;
            w.init = 1'b0;
            exp_q.push_back(w);
            model_esc = 1'b0;
        end
    endtask

    // FIFO model: the head advances just after the edge that consumed it
    logic       fifo_empty_r = 1'b1;
    logic [7:0] fifo_out_r   = 8'h00;
    bit         rd_seen      = 1'b0;
    assign bus.fifo_empty = fifo_empty_r;
    assign bus.fifo_out   = fifo_out_r;

    always @(posedge clock) begin
        #1;
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty_r = (fifo_q.size() == 0);
        fifo_out_r   = fifo_empty_r ? 8'h00 : fifo_q[0];
    end

    // Bus monitor
    bit          e_prev, id_prev, have_prev, have_read, first_init;
    int unsigned rise_cyc, prev_rise_cyc, prev_w, last_read_cyc, rel_cyc;
    logic [7:0]  cur_data, last_data;
    logic        cur_rs, last_rs;
    int          writes_seen = 0;

    always @(negedge clock) begin
        if (reset) begin
            e_prev     = 1'b0;
            id_prev    = 1'b0;
            have_prev  = 1'b0;
            have_read  = 1'b0;
            first_init = 1'b1;
            rd_seen    = 1'b0;
        end else begin
            rd_seen = bus.fifo_out_read;
            if (bus.fifo_out_read) begin
                chk("read_after_init", 32'(init_done), 32'd1);
                if (have_read) chk("read_spacing", 32'((cyc - last_read_cyc) > 1), 32'd1);
                if (have_prev) chk("read_gap", 32'((cyc - prev_rise_cyc) >= EN + prev_w), 32'd1);
                last_read_cyc = cyc;
                have_read     = 1'b1;
            end
            if (bus.lcd_e && !e_prev) begin
                wr_t w;
                writes_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data 0x%0h rs %0d, expected none",
                             bus.lcd_data, bus.lcd_rs);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_data", 32'(bus.lcd_data), 32'(w.data));
                    chk("wr_rs", 32'(bus.lcd_rs), 32'(w.rs));
                    if (w.init && first_init)
                        chk("powerup_delay", cyc - rel_cyc, POWERUP + 2);
                    else if (w.init)
                        chk("init_spacing", cyc - prev_rise_cyc, 2 + EN + prev_w);
                    else
                        chk("read_to_e", cyc - last_read_cyc, 32'd2);
                    first_init = 1'b0;
                end
                chk("lcd_rw", 32'(bus.lcd_rw), 32'd0);
                cur_data      = bus.lcd_data;
                cur_rs        = bus.lcd_rs;
                last_data     = bus.lcd_data;
                last_rs       = bus.lcd_rs;
                rise_cyc      = cyc;
                prev_rise_cyc = cyc;
                prev_w        = wait_of(bus.lcd_data, bus.lcd_rs);
                have_prev     = 1'b1;
            end else if (bus.lcd_e) begin
                chk("data_hold_pulse", 32'({bus.lcd_rs, bus.lcd_data}), 32'({cur_rs, cur_data}));
            end
            if (!bus.lcd_e && e_prev) begin
                chk("e_width", cyc - rise_cyc, EN);
                chk("data_hold_wait", 32'({bus.lcd_rs, bus.lcd_data}), 32'({cur_rs, cur_data}));
            end
            if (init_done && !id_prev) chk("init_done_time", cyc - prev_rise_cyc, EN + CMD);
            e_prev  = bus.lcd_e;
            id_prev = init_done;
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (fifo_q.size() == 0 && !busy && exp_q.size() == 0 && !bus.lcd_e) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_init(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_init_done"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_e"}, 32'(bus.lcd_e), 32'd0);
        chk({name, "_data"}, 32'(bus.lcd_data), 32'd0);
        chk({name, "_rs"}, 32'(bus.lcd_rs), 32'd0);
        chk({name, "_rw"}, 32'(bus.lcd_rw), 32'd0);
        chk({name, "_read"}, 32'(bus.fifo_out_read), 32'd0);
        chk({name, "_init_done"}, 32'(init_done), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    typedef struct {
        logic [7:0] b[3];
        int         n;
        int         n_wr;
        logic [7:0] last_data;
        logic       last_rs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         base;
        logic [7:0] rb;
        bit         ok;

        init_bytes[0] = 8'h38; init_bytes[1] = 8'h38; init_bytes[2] = 8'h0C;
        init_bytes[3] = 8'h01; init_bytes[4] = 8'h06;

        vecs[0] = '{'{8'h41, 8'h00, 8'h00}, 1, 1, 8'h41, 1'b1};
        vecs[1] = '{'{8'hFE, 8'h01, 8'h00}, 2, 1, 8'h01, 1'b0};
        vecs[2] = '{'{8'hFE, 8'hFE, 8'h42}, 3, 2, 8'h42, 1'b1};
        vecs[3] = '{'{8'hFE, 8'hFE, 8'h00}, 2, 1, 8'hFE, 1'b0};
        vecs[4] = '{'{8'h43, 8'h00, 8'h00}, 1, 1, 8'h43, 1'b1};
        vecs[5] = '{'{8'h02, 8'h01, 8'h00}, 2, 2, 8'h01, 1'b1};
        vecs[6] = '{'{8'hFE, 8'h02, 8'h00}, 2, 1, 8'h02, 1'b0};

        model_init();
        repeat (2) @(negedge clock);
        #2;
        check_reset_values("reset");
        reset   = 1'b0;
        rel_cyc = cyc;

        wait_init("powerup");
        chk("init_write_count", 32'(writes_seen), 32'd5);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_exp_drained", 32'(exp_q.size()), 32'd0);

        foreach (vecs[v]) begin
            base = writes_seen;
            @(negedge clock);
            #2;
            for (int i = 0; i < vecs[v].n; i++) push_byte(vecs[v].b[i]);
            wait_idle("vec");
            chk("vec_writes", 32'(writes_seen - base), 32'(vecs[v].n_wr));
            chk("vec_last_data", 32'(last_data), 32'(vecs[v].last_data));
            chk("vec_last_rs", 32'(last_rs), 32'(vecs[v].last_rs));
        end

        // Escape held across a long empty stretch
        base = writes_seen;
        @(negedge clock);
        #2;
        push_byte(8'hFE);
        repeat (100) @(negedge clock);
        chk("esc_idle_writes", 32'(writes_seen - base), 32'd0);
        chk("esc_idle_busy", 32'(busy), 32'd0);
        chk("esc_idle_consumed", 32'(fifo_q.size()), 32'd0);
        #2;
        push_byte(8'h80);
        wait_idle("esc_late");
        chk("esc_late_data", 32'(last_data), 32'h80);
        chk("esc_late_rs", 32'(last_rs), 32'd0);

        // Random traffic against the model
        base = writes_seen;
        begin
            int exp_wr;
            exp_wr = 0;
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 7))
                    0, 1:    rb = 8'hFE;
                    2:       rb = 8'h01;
                    3:       rb = 8'h02;
                    default: rb = 8'($urandom);
                endcase
                if (!(rb == 8'hFE && !model_esc)) exp_wr++;
                @(negedge clock);
                #2;
                push_byte(rb);
                repeat ($urandom_range(0, 30)) @(negedge clock);
            end
            if (model_esc) begin
                @(negedge clock);
                #2;
                push_byte(8'h55);
                exp_wr++;
            end
            wait_idle("random");
            chk("random_writes", 32'(writes_seen - base), 32'(exp_wr));
        end

        // Reset in the middle of an enable pulse
        @(negedge clock);
        #2;
        push_byte(8'h41);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.lcd_e) begin
                ok = 1'b1;
                break;
            end
        end
        chk("pulse_seen", 32'(ok), 32'd1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        fifo_q.delete();
        model_esc = 1'b0;
        model_init();
        repeat (3) @(negedge clock);
        #2;
        reset   = 1'b0;
        rel_cyc = cyc;
        base    = writes_seen;
        wait_init("reinit");
        chk("reinit_writes", 32'(writes_seen - base), 32'd5);
        chk("reinit_exp_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clock);
        chk("reinit_no_read", 32'(have_read), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
